// File: rtl/uart_stream_xcvr_if.sv
// Valid/ready stream bundle for the UART transceiver.
// Master is the byte producer/consumer; slave is the transceiver.
interface uart_stream_xcvr_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_perr, rx_ferr,
        input  rx_valid, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_perr, rx_ferr,
        output rx_valid, rx_overrun
    );
endinterface

// File: rtl/uart_stream_xcvr.sv
// Full-duplex UART: TX serialiser, RX deserialiser, RX FIFO.
// Streams on both sides; txout may be looped back to rxin.
module uart_stream_xcvr #(
    parameter int PERIOD    = 8'h1A,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 2
) (
    input  logic                clk,
    input  logic                reset,
    uart_stream_xcvr_if.slave   s,
    output logic                txout,
    input  logic                rxin
);
    localparam int CW    = $clog2(STOP_BITS * PERIOD + 1);
    localparam int IW    = $clog2(DATA_BITS);
    localparam int PW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = DATA_BITS + 2;

    localparam logic [CW-1:0] BIT_END  = CW'(PERIOD - 1);
    localparam logic [CW-1:0] HALF_END = CW'(PERIOD / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * PERIOD - 1);
    localparam logic [IW-1:0] IDX_END  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_e;

    // ---------------- TX ----------------
    state_e               tx_state_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [IW-1:0]        tx_idx_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_par_q;
    logic                 txout_q;
    logic                 tx_ready_q;

    // TX frame sequencer; each state holds its bit for PERIOD clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            txout_q    <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            unique case (tx_state_q)
                S_IDLE: begin
                    if (s.tx_valid) begin
                        tx_sh_q    <= s.tx_data;
                        tx_par_q   <= (PARITY == 2) ? ~^s.tx_data
                                                    : ^s.tx_data;
                        txout_q    <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        txout_q    <= tx_sh_q[0];
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == IDX_END) begin
                            if (PARITY != 0) begin
                                txout_q    <= tx_par_q;
                                tx_state_q <= S_PAR;
                            end else begin
                                txout_q    <= 1'b1;
                                tx_state_q <= S_STOP;
                            end
                        end else begin
                            tx_idx_q <= tx_idx_q + IW'(1);
                            tx_sh_q  <= tx_sh_q >> 1;
                            txout_q  <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_PAR: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        txout_q    <= 1'b1;
                        tx_state_q <= S_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tx_cnt_q == STOP_END) begin
                        tx_cnt_q   <= '0;
                        tx_ready_q <= 1'b1;
                        tx_state_q <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    assign txout      = txout_q;
    assign s.tx_ready = tx_ready_q;

    // ---------------- RX ----------------
    logic rs1_q, rs1_d;
    logic rs_q, rs_d;

    // two-flop synchroniser for the asynchronous serial input
    always_comb begin
        rs1_d = rxin;
        rs_d  = rs1_q;
    end

    // synchroniser flops idle high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1_q <= 1'b1;
            rs_q  <= 1'b1;
        end else begin
            rs1_q <= rs1_d;
            rs_q  <= rs_d;
        end
    end

    state_e               rx_state_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [IW-1:0]        rx_idx_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_par_q;

    // RX frame sequencer; samples mid-bit after validating the start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            unique case (rx_state_q)
                S_IDLE: begin
                    if (!rs_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q   <= '0;
                        rx_idx_q   <= '0;
                        rx_state_q <= rs_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rs_q, rx_sh_q[DATA_BITS-1:1]};
                        if (rx_idx_q == IDX_END) begin
                            rx_state_q <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + IW'(1);
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                S_PAR: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_par_q   <= rs_q;
                        rx_state_q <= S_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic          push;
    logic          perr;
    logic [FW-1:0] wdata;
    logic          empty, full, pop, wr_en;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic          ovr_q, ovr_d;
    logic [FW-1:0] mem_q [DEPTH];
    logic [FW-1:0] mem_d [DEPTH];
    logic [FW-1:0] head;

    // push at the stop sample so the entry is visible the next cycle
    always_comb begin
        push = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_END);
        perr = 1'b0;
        if (PARITY == 1) perr = ^rx_sh_q ^ rx_par_q;
        if (PARITY == 2) perr = ~(^rx_sh_q ^ rx_par_q);
        wdata = {~rs_q, perr, rx_sh_q};
    end

    // pointer/storage next state; a full FIFO only accepts with a pop
    always_comb begin
        empty = (wr_q == rd_q);
        full  = (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0])
             && (wr_q[FIFO_AW] != rd_q[FIFO_AW]);
        pop   = !empty && s.rx_ready;
        wr_en = push && (!full || pop);
        mem_d = mem_q;
        if (wr_en) mem_d[wr_q[FIFO_AW-1:0]] = wdata;
        wr_d  = wr_q + PW'(wr_en);
        rd_d  = rd_q + PW'(pop);
        ovr_d = push && full && !pop;
    end

    // FIFO pointers and overrun pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovr_q <= ovr_d;
        end
    end

    // storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head         = mem_q[rd_q[FIFO_AW-1:0]];
    assign s.rx_valid   = !empty;
    assign s.rx_data    = empty ? '0 : head[DATA_BITS-1:0];
    assign s.rx_perr    = !empty && head[DATA_BITS];
    assign s.rx_ferr    = !empty && head[DATA_BITS+1];
    assign s.rx_overrun = ovr_q;
endmodule

// File: tb/tb_uart_stream_xcvr.sv
// Directed bench for uart_stream_xcvr: three instances
// (no/even/odd parity), u1 looped back txout->rxin.
module tb_uart_stream_xcvr;
    logic clk = 1'b0;
    logic reset;
    logic rxd0, rxd2;
    logic txo0, txo1, txo2;
    int   errors = 0;
    int   checks = 0;
    int   ovr_cnt = 0;
    int   ov0;

    always #5 clk = ~clk;

    uart_stream_xcvr_if #(.DATA_BITS(8)) s0 ();
    uart_stream_xcvr_if #(.DATA_BITS(8)) s1 ();
    uart_stream_xcvr_if #(.DATA_BITS(8)) s2 ();

    uart_stream_xcvr #(
        .PERIOD(16), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_AW(2)
    ) u0 (
        .clk(clk), .reset(reset), .s(s0),
        .txout(txo0), .rxin(rxd0)
    );

    uart_stream_xcvr #(
        .PERIOD(16), .DATA_BITS(8), .PARITY(1),
        .STOP_BITS(1), .FIFO_AW(2)
    ) u1 (
        .clk(clk), .reset(reset), .s(s1),
        .txout(txo1), .rxin(txo1)
    );

    uart_stream_xcvr #(
        .PERIOD(16), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_AW(2)
    ) u2 (
        .clk(clk), .reset(reset), .s(s2),
        .txout(txo2), .rxin(rxd2)
    );

    always @(negedge clk) begin
        if (s0.rx_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] fr0(input logic [7:0] d);
        return {2'b11, d, 1'b0};
    endfunction

    function automatic logic [10:0] fr2(input logic [7:0] d,
                                        input logic p, input logic st);
        return {st, p, d, 1'b0};
    endfunction

    // drive nb bits LSB first, 16 clocks each; optional one-cycle
    // pop on u0 at negedge number pop_at counted from frame start
    task automatic drive(input int which, input logic [10:0] bits,
                         input int nb, input int pop_at);
        for (int b = 0; b < nb; b++) begin
            if (which == 0) rxd0 = bits[b];
            else rxd2 = bits[b];
            for (int j = 1; j <= 16; j++) begin
                @(negedge clk);
                if (b * 16 + j == pop_at) s0.rx_ready = 1'b1;
                if (b * 16 + j == pop_at + 1) s0.rx_ready = 1'b0;
            end
        end
        if (which == 0) rxd0 = 1'b1;
        else rxd2 = 1'b1;
    endtask

    task automatic pop0(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, s0.rx_valid, 1);
        chk({tag, "_data"}, s0.rx_data, exp);
        s0.rx_ready = 1'b1;
        @(negedge clk);
        s0.rx_ready = 1'b0;
    endtask

    task automatic pop1(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, s1.rx_valid, 1);
        chk({tag, "_data"}, s1.rx_data, exp);
        chk({tag, "_perr"}, s1.rx_perr, 0);
        chk({tag, "_ferr"}, s1.rx_ferr, 0);
        s1.rx_ready = 1'b1;
        @(negedge clk);
        s1.rx_ready = 1'b0;
    endtask

    initial begin
        logic [9:0] frame;
        reset = 1'b0;
        rxd0 = 1'b1;
        rxd2 = 1'b1;
        s0.tx_valid = 0; s0.tx_data = 0; s0.rx_ready = 0;
        s1.tx_valid = 0; s1.tx_data = 0; s1.rx_ready = 0;
        s2.tx_valid = 0; s2.tx_data = 0; s2.rx_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_txout", txo0, 1);
        chk("rst_tx_ready", s0.tx_ready, 1);
        chk("rst_rx_valid", s0.rx_valid, 0);
        chk("rst_rx_data", s0.rx_data, 0);
        chk("rst_perr", s0.rx_perr, 0);
        chk("rst_ferr", s0.rx_ferr, 0);
        chk("rst_overrun", s0.rx_overrun, 0);
        reset = 1'b1;
        @(negedge clk);

        // TX waveform of 8'hA5, no parity
        frame = {1'b1, 8'hA5, 1'b0};
        s0.tx_data = 8'hA5;
        s0.tx_valid = 1'b1;
        @(negedge clk);
        s0.tx_valid = 1'b0;
        for (int j = 1; j <= 160; j++) begin
            if (j == 1 || j == 160) chk("t1_busy", s0.tx_ready, 0);
            if (j % 16 == 1 || j % 16 == 0)
                chk($sformatf("t1_bit%0d_c%0d", (j - 1) / 16, j),
                    txo0, frame[(j - 1) / 16]);
            if (j == 50) begin
                s0.tx_data = 8'hFF;
                s0.tx_valid = 1'b1;
            end
            if (j == 51) s0.tx_valid = 1'b0;
            @(negedge clk);
        end
        chk("t1_ready_back", s0.tx_ready, 1);
        chk("t1_idle_high", txo0, 1);

        // short low glitch on rxin is not a start bit
        rxd0 = 1'b0;
        repeat (6) @(negedge clk);
        rxd0 = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_no_frame", s0.rx_valid, 0);
        s0.rx_ready = 1'b1;
        @(negedge clk);
        s0.rx_ready = 1'b0;
        drive(0, fr0(8'h5A), 10, 0);
        chk("t5_perr", s0.rx_perr, 0);
        chk("t5_ferr", s0.rx_ferr, 0);
        pop0("t5_after", 8'h5A);
        chk("t5_empty", s0.rx_valid, 0);

        // FIFO fill, overrun on 5th, push+pop when full
        ov0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) drive(0, fr0(8'(i)), 10, 0);
        chk("t4_no_ovr_4", ovr_cnt - ov0, 0);
        chk("t4_head_4", s0.rx_data, 8'h01);
        drive(0, fr0(8'h05), 10, 0);
        repeat (2) @(negedge clk);
        chk("t4_ovr_5", ovr_cnt - ov0, 1);
        chk("t4_head_5", s0.rx_data, 8'h01);
        drive(0, fr0(8'h06), 10, 154);
        repeat (2) @(negedge clk);
        chk("t4_no_ovr_6", ovr_cnt - ov0, 1);
        pop0("t4_p0", 8'h02);
        pop0("t4_p1", 8'h03);
        pop0("t4_p2", 8'h04);
        pop0("t4_p3", 8'h06);
        chk("t4_empty", s0.rx_valid, 0);

        // loopback, even parity, back-to-back
        s1.tx_data = 8'h3C;
        s1.tx_valid = 1'b1;
        @(negedge clk);
        s1.tx_data = 8'h81;
        for (int i = 0; i < 400 && !s1.tx_ready; i++) @(negedge clk);
        chk("t2_ready_back", s1.tx_ready, 1);
        @(negedge clk);
        s1.tx_valid = 1'b0;
        chk("t2_b2b_accept", s1.tx_ready, 0);
        for (int i = 0; i < 400 && !s1.tx_ready; i++) @(negedge clk);
        chk("t2_ready_end", s1.tx_ready, 1);
        repeat (20) @(negedge clk);
        pop1("t2_a", 8'h3C);
        pop1("t2_b", 8'h81);
        chk("t2_empty", s1.rx_valid, 0);

        // odd parity: flipped parity bit, then low stop bit
        drive(2, fr2(8'h07, 1'b1, 1'b1), 11, 0);
        repeat (5) @(negedge clk);
        chk("t3_valid", s2.rx_valid, 1);
        chk("t3_data", s2.rx_data, 8'h07);
        chk("t3_perr", s2.rx_perr, 1);
        chk("t3_ferr", s2.rx_ferr, 0);
        s2.rx_ready = 1'b1;
        @(negedge clk);
        s2.rx_ready = 1'b0;
        chk("t3_empty", s2.rx_valid, 0);
        drive(2, fr2(8'h07, 1'b0, 1'b0), 11, 0);
        repeat (40) @(negedge clk);
        chk("t3f_valid", s2.rx_valid, 1);
        chk("t3f_data", s2.rx_data, 8'h07);
        chk("t3f_perr", s2.rx_perr, 0);
        chk("t3f_ferr", s2.rx_ferr, 1);
        s2.rx_ready = 1'b1;
        @(negedge clk);
        s2.rx_ready = 1'b0;
        chk("t3f_empty", s2.rx_valid, 0);

        // reset mid TX data bit and mid RX frame
        s1.tx_data = 8'h11;
        s1.tx_valid = 1'b1;
        @(negedge clk);
        s1.tx_valid = 1'b0;
        for (int i = 0; i < 400 && !s1.tx_ready; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("t6_pre_valid", s1.rx_valid, 1);
        chk("t6_pre_data", s1.rx_data, 8'h11);
        s1.tx_data = 8'h00;
        s1.tx_valid = 1'b1;
        @(negedge clk);
        s1.tx_valid = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_mid_low", txo1, 0);
        #2 reset = 1'b0;
        #1;
        chk("t6_txout", txo1, 1);
        chk("t6_tx_ready", s1.tx_ready, 1);
        chk("t6_rx_valid", s1.rx_valid, 0);
        chk("t6_rx_data", s1.rx_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        s1.tx_data = 8'h96;
        s1.tx_valid = 1'b1;
        @(negedge clk);
        s1.tx_valid = 1'b0;
        for (int i = 0; i < 400 && !s1.tx_ready; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        pop1("t6_post", 8'h96);
        chk("t6_empty", s1.rx_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
